// File: rtl/rs_issue_scheduler_pkg.sv
// Shared definitions for the reservation-station issue scheduler.
// Contents: RS/FU geometry, FU encodings, the registered grant record and
// a ROB-age helper used by the oldest-first picker.
package rs_issue_scheduler_pkg;

    localparam int RS_ROWS = 16;
    localparam int NUM_FUS = 3;

    localparam logic [1:0] FU_ALU0 = 2'd0;
    localparam logic [1:0] FU_ALU1 = 2'd1;
    localparam logic [1:0] FU_MUL  = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [3:0] row;
        logic [3:0] rob;
    } issue_grant;

    // Distance from the ROB head; 4-bit wraparound gives mod-16 for free.
    function automatic logic [3:0] rob_age(logic [3:0] rob, logic [3:0] head);
        return rob - head;
    endfunction

endpackage

// File: rtl/rs_issue_scheduler_if.sv
// RS <-> scheduler bus.
// master: RS owner side; drives row state and rob_head, receives grants.
// slave : scheduler side; receives row state, drives issue_valid/row/rob,
//         rs_clear and fu_idle.
interface rs_issue_scheduler_if #(
    parameter int NUM_RS = 16,
    parameter int NUM_FU = 3
);
    logic [NUM_RS-1:0]   rs_valid;
    logic [NUM_RS-1:0]   rs_src1_ready;
    logic [NUM_RS-1:0]   rs_src2_ready;
    logic [2*NUM_RS-1:0] rs_fu_index;
    logic [4*NUM_RS-1:0] rs_rob_index;
    logic [3:0]          rob_head;
    logic [NUM_FU-1:0]   issue_valid;
    logic [4*NUM_FU-1:0] issue_row;
    logic [4*NUM_FU-1:0] issue_rob;
    logic [NUM_RS-1:0]   rs_clear;
    logic [NUM_FU-1:0]   fu_idle;

    modport master (
        output rs_valid, rs_src1_ready, rs_src2_ready, rs_fu_index,
               rs_rob_index, rob_head,
        input  issue_valid, issue_row, issue_rob, rs_clear, fu_idle
    );

    modport slave (
        input  rs_valid, rs_src1_ready, rs_src2_ready, rs_fu_index,
               rs_rob_index, rob_head,
        output issue_valid, issue_row, issue_rob, rs_clear, fu_idle
    );
endinterface

// File: rtl/rs_issue_scheduler_oldest_pick.sv
// rs_oldest_pick: combinational single-winner picker over an eligible mask.
// Ports: eligible (row mask), rob_index (4 bits per row), rob_head,
//        found (any eligible), row (winning row index).
// Config: RS_ISSUE_AGE_EN selects smallest ROB age (ties -> lowest row);
//         otherwise lowest eligible row wins and ROB inputs are ignored.
module rs_oldest_pick
    import rs_issue_scheduler_pkg::*;
#(
    parameter int NUM_RS = RS_ROWS
) (
    input  logic [NUM_RS-1:0]   eligible,
    input  logic [4*NUM_RS-1:0] rob_index,
    input  logic [3:0]          rob_head,
    output logic                found,
    output logic [3:0]          row
);

`ifdef RS_ISSUE_AGE_EN
    logic [3:0] age;
    logic [3:0] best_age;

    always_comb begin
        found    = 1'b0;
        row      = '0;
        age      = '0;
        best_age = '0;
        // Strict less-than keeps the lower row on equal age.
        for (int unsigned r = 0; r < NUM_RS; r++) begin
            age = rob_age(rob_index[4*r +: 4], rob_head);
            if (eligible[r] && (!found || age < best_age)) begin
                found    = 1'b1;
                row      = 4'(r);
                best_age = age;
            end
        end
    end
`else
    logic unused_rob;
    assign unused_rob = ^{rob_index, rob_head};

    always_comb begin
        found = 1'b0;
        row   = '0;
        for (int unsigned r = 0; r < NUM_RS; r++) begin
            if (eligible[r] && !found) begin
                found = 1'b1;
                row   = 4'(r);
            end
        end
    end
`endif

endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: grants at most one ready RS row per functional unit
// per cycle, registered one cycle after eligibility.
// Ports: clk, rst (sync, active-high), flush (drop pending/in-flight state),
//        stall (no new grants), bus (rs_issue_scheduler_if.slave: RS row
//        state in; issue_valid/row/rob, rs_clear pulses, fu_idle out).
// Config: RS_ISSUE_AGE_EN -> oldest-first by ROB age, else lowest row.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
#(
    parameter int NUM_RS  = RS_ROWS,
    parameter int NUM_FU  = NUM_FUS,
    parameter int FU0_LAT = 1,
    parameter int FU1_LAT = 1,
    parameter int FU2_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic stall,
    rs_issue_scheduler_if.slave bus
);

    function automatic logic [2:0] fu_reload(int unsigned f);
        case (f)
            0:       return 3'(FU0_LAT - 1);
            1:       return 3'(FU1_LAT - 1);
            default: return 3'(FU2_LAT - 1);
        endcase
    endfunction

    logic [NUM_RS-1:0] pending;
    logic [NUM_RS-1:0] ready;
    logic [NUM_RS-1:0] grant_mask;
    logic [NUM_RS-1:0] clear_q;
    logic [2:0]        busy_cnt [NUM_FU];
    issue_grant        grant_q  [NUM_FU];
    logic [NUM_FU-1:0] pick_found;
    logic [3:0]        pick_row [NUM_FU];

    // pending masks a granted row until its in_use bit has dropped once.
    assign ready = bus.rs_valid & bus.rs_src1_ready & bus.rs_src2_ready & ~pending;

    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
        logic [NUM_RS-1:0] elig;

        always_comb begin
            elig = '0;
            for (int unsigned r = 0; r < NUM_RS; r++) begin
                elig[r] = ready[r] && (bus.rs_fu_index[2*r +: 2] == 2'(f));
            end
            if (busy_cnt[f] != '0 || stall || flush) begin
                elig = '0;
            end
        end

        rs_oldest_pick #(.NUM_RS(NUM_RS)) u_pick (
            .eligible  (elig),
            .rob_index (bus.rs_rob_index),
            .rob_head  (bus.rob_head),
            .found     (pick_found[f]),
            .row       (pick_row[f])
        );
    end

    // Each row targets a single FU, so winners never collide in the mask.
    always_comb begin
        grant_mask = '0;
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            if (pick_found[f]) begin
                grant_mask[pick_row[f]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            clear_q <= '0;
            for (int unsigned f = 0; f < NUM_FU; f++) begin
                busy_cnt[f] <= '0;
                grant_q[f]  <= '0;
            end
        end else if (flush) begin
            pending <= '0;
            clear_q <= '0;
            for (int unsigned f = 0; f < NUM_FU; f++) begin
                busy_cnt[f]      <= '0;
                grant_q[f].valid <= 1'b0;
            end
        end else begin
            pending <= (pending & bus.rs_valid) | grant_mask;
            clear_q <= grant_mask;
            for (int unsigned f = 0; f < NUM_FU; f++) begin
                if (pick_found[f]) begin
                    grant_q[f]  <= '{valid: 1'b1,
                                     row:   pick_row[f],
                                     rob:   bus.rs_rob_index[4*pick_row[f] +: 4]};
                    busy_cnt[f] <= fu_reload(f);
                end else begin
                    grant_q[f].valid <= 1'b0;
                    if (busy_cnt[f] != '0) begin
                        busy_cnt[f] <= busy_cnt[f] - 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.issue_valid = '0;
        bus.issue_row   = '0;
        bus.issue_rob   = '0;
        bus.fu_idle     = '0;
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            bus.issue_valid[f]      = grant_q[f].valid;
            bus.issue_row[4*f +: 4] = grant_q[f].row;
            bus.issue_rob[4*f +: 4] = grant_q[f].rob;
            bus.fu_idle[f]          = (busy_cnt[f] == '0);
        end
    end

    assign bus.rs_clear = clear_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
module tb_rs_issue_scheduler;
    logic clk = 1'b0;
    logic rst, flush, stall;
    always #5 clk = ~clk;

    rs_issue_scheduler_if #(.NUM_RS(16), .NUM_FU(3)) bus ();

    rs_issue_scheduler #(
        .NUM_RS(16), .NUM_FU(3), .FU0_LAT(1), .FU1_LAT(1), .FU2_LAT(3)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          lat [3] = '{1, 1, 3};
    int          m_busy [3];
    bit          m_pending [16];
    logic [2:0]  exp_valid;
    logic [11:0] exp_row, exp_rob;
    logic [15:0] exp_clear;
    logic [15:0] m_gmask;
    bit          model_ok = 0;
    int          win, best, key;

    always @(posedge clk) begin
        model_ok = 1;
        if (rst) begin
            exp_valid = 0; exp_row = 0; exp_rob = 0; exp_clear = 0;
            foreach (m_busy[f]) m_busy[f] = 0;
            foreach (m_pending[r]) m_pending[r] = 0;
        end else if (flush) begin
            exp_valid = 0; exp_clear = 0;
            foreach (m_busy[f]) m_busy[f] = 0;
            foreach (m_pending[r]) m_pending[r] = 0;
        end else begin
            m_gmask = 0;
            exp_valid = 0;
            for (int f = 0; f < 3; f++) begin
                win = -1;
                best = 1 << 30;
                if (!stall && m_busy[f] == 0) begin
                    for (int r = 0; r < 16; r++) begin
                        if (bus.rs_valid[r] && bus.rs_src1_ready[r] && bus.rs_src2_ready[r]
                            && !m_pending[r] && int'(bus.rs_fu_index[2*r +: 2]) == f) begin
`ifdef RS_ISSUE_AGE_EN
                            key = ((int'(bus.rs_rob_index[4*r +: 4]) - int'(bus.rob_head) + 16) % 16) * 16 + r;
`else
                            key = r;
`endif
                            if (key < best) begin
                                best = key;
                                win = r;
                            end
                        end
                    end
                end
                if (win >= 0) begin
                    exp_valid[f] = 1'b1;
                    exp_row[4*f +: 4] = 4'(win);
                    exp_rob[4*f +: 4] = bus.rs_rob_index[4*win +: 4];
                    m_gmask[win] = 1'b1;
                    m_busy[f] = lat[f] - 1;
                end else if (m_busy[f] > 0) begin
                    m_busy[f] = m_busy[f] - 1;
                end
            end
            for (int r = 0; r < 16; r++)
                m_pending[r] = (m_pending[r] && bus.rs_valid[r]) || m_gmask[r];
            exp_clear = m_gmask;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model.issue_valid", 32'(bus.issue_valid), 32'(exp_valid));
            check("model.issue_row", 32'(bus.issue_row), 32'(exp_row));
            check("model.issue_rob", 32'(bus.issue_rob), 32'(exp_rob));
            check("model.rs_clear", 32'(bus.rs_clear), 32'(exp_clear));
            check("model.fu_idle", 32'(bus.fu_idle),
                  {29'd0, m_busy[2] == 0, m_busy[1] == 0, m_busy[0] == 0});
        end
    end

    // ---------------- stimulus helpers ----------------
    bit auto_release = 0;

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (auto_release) bus.rs_valid = bus.rs_valid & ~bus.rs_clear;
        end
    endtask

    task automatic clear_rows();
        bus.rs_valid = '0;
        bus.rs_src1_ready = '0;
        bus.rs_src2_ready = '0;
        bus.rs_fu_index = '0;
        bus.rs_rob_index = '0;
    endtask

    task automatic set_row(int r, logic [1:0] fu, logic [3:0] rob);
        bus.rs_valid[r] = 1'b1;
        bus.rs_src1_ready[r] = 1'b1;
        bus.rs_src2_ready[r] = 1'b1;
        bus.rs_fu_index[2*r +: 2] = fu;
        bus.rs_rob_index[4*r +: 4] = rob;
    endtask

    task automatic drain();
        clear_rows();
        tick(4);
    endtask

    initial begin
        rst = 1; flush = 0; stall = 0;
        bus.rob_head = 4'd0;
        clear_rows();
        for (int r = 0; r < 16; r++) set_row(r, 2'(r % 3), 4'(r));
        tick(2);
        check("rst.issue_valid", 32'(bus.issue_valid), 32'h0);
        check("rst.rs_clear", 32'(bus.rs_clear), 32'h0);
        check("rst.issue_row", 32'(bus.issue_row), 32'h0);
        check("rst.issue_rob", 32'(bus.issue_rob), 32'h0);
        check("rst.fu_idle", 32'(bus.fu_idle), 32'h7);
        rst = 0;
        auto_release = 1;
        tick(1);
        check("first.issue_valid", 32'(bus.issue_valid), 32'h7);
        check("first.rs_clear", 32'(bus.rs_clear), 32'h0007);
        check("first.issue_row", 32'(bus.issue_row), 32'h210);
        drain();

        // age wrap: head 14, row 2 -> ROB 0, row 9 -> ROB 15
        bus.rob_head = 4'd14;
        set_row(2, 2'd0, 4'd0);
        set_row(9, 2'd0, 4'd15);
        tick(1);
`ifdef RS_ISSUE_AGE_EN
        check("age.row", 32'(bus.issue_row[3:0]), 32'd9);
        check("age.rob", 32'(bus.issue_rob[3:0]), 32'd15);
        check("age.clear", 32'(bus.rs_clear), 32'h0200);
        tick(1);
        check("age.second_row", 32'(bus.issue_row[3:0]), 32'd2);
`else
        check("prio.row", 32'(bus.issue_row[3:0]), 32'd2);
        check("prio.rob", 32'(bus.issue_rob[3:0]), 32'd0);
        check("prio.clear", 32'(bus.rs_clear), 32'h0004);
        tick(1);
        check("prio.second_row", 32'(bus.issue_row[3:0]), 32'd9);
`endif
        check("age.second_valid", 32'(bus.issue_valid[0]), 32'd1);
        drain();

        // FU2 latency 3: grants every third edge
        bus.rob_head = 4'd0;
        for (int k = 0; k < 4; k++) set_row(10 + k, 2'd2, 4'(10 + k));
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("lat.grant_valid", 32'(bus.issue_valid[2]), 32'd1);
            check("lat.grant_row", 32'(bus.issue_row[11:8]), 32'(10 + k));
            check("lat.idle_e1", 32'(bus.fu_idle[2]), 32'd0);
            tick(1);
            check("lat.gap_valid", 32'(bus.issue_valid[2]), 32'd0);
            check("lat.idle_e2", 32'(bus.fu_idle[2]), 32'd0);
            if (k < 3) begin
                tick(1);
                check("lat.idle_e3", 32'(bus.fu_idle[2]), 32'd1);
                check("lat.gap2_valid", 32'(bus.issue_valid[2]), 32'd0);
            end
        end
        drain();

        // pending mask: row 5 held valid after its grant
        auto_release = 0;
        set_row(5, 2'd1, 4'd5);
        tick(1);
        check("pend.grant", 32'(bus.issue_valid), 32'h2);
        check("pend.clear", 32'(bus.rs_clear), 32'h0020);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("pend.masked", 32'(bus.issue_valid), 32'h0);
        end
        bus.rs_valid[5] = 1'b0;
        tick(1);
        check("pend.dropped", 32'(bus.issue_valid), 32'h0);
        bus.rs_valid[5] = 1'b1;
        tick(1);
        check("pend.regrant", 32'(bus.issue_valid), 32'h2);
        check("pend.regrant_row", 32'(bus.issue_row[7:4]), 32'd5);
        drain();

        // stall: FU2 countdown still expires
        auto_release = 1;
        set_row(6, 2'd2, 4'd6);
        tick(1);
        check("stall.pre_grant", 32'(bus.issue_valid), 32'h4);
        stall = 1;
        set_row(0, 2'd0, 4'd0);
        set_row(8, 2'd2, 4'd8);
        tick(1);
        check("stall.c1_valid", 32'(bus.issue_valid), 32'h0);
        check("stall.c1_idle", 32'(bus.fu_idle), 32'h3);
        tick(1);
        check("stall.c2_valid", 32'(bus.issue_valid), 32'h0);
        check("stall.c2_idle", 32'(bus.fu_idle), 32'h7);
        stall = 0;
        tick(1);
        check("stall.release", 32'(bus.issue_valid), 32'h5);
        check("stall.rows", 32'({bus.issue_row[11:8], bus.issue_row[3:0]}), 32'h80);
        drain();

        // flush clears pending of a still-valid row
        auto_release = 0;
        set_row(4, 2'd0, 4'd4);
        tick(1);
        check("flush.pre_grant", 32'(bus.issue_valid), 32'h1);
        flush = 1;
        tick(1);
        check("flush.valid", 32'(bus.issue_valid), 32'h0);
        check("flush.clear", 32'(bus.rs_clear), 32'h0);
        flush = 0;
        tick(1);
        check("flush.regrant", 32'(bus.issue_valid), 32'h1);
        check("flush.row", 32'(bus.issue_row[3:0]), 32'd4);
        drain();

        // parallel FUs
        auto_release = 1;
        set_row(3, 2'd0, 4'd3);
        set_row(4, 2'd1, 4'd4);
        set_row(7, 2'd2, 4'd7);
        tick(1);
        check("par.valid", 32'(bus.issue_valid), 32'h7);
        check("par.clear", 32'(bus.rs_clear), 32'h0098);
        check("par.rows", 32'(bus.issue_row), 32'h743);
        drain();
        set_row(1, 2'd0, 4'd1);
        set_row(3, 2'd0, 4'd3);
        tick(1);
        check("par.low_row", 32'(bus.issue_row[3:0]), 32'd1);
        check("par.low_clear", 32'(bus.rs_clear), 32'h0002);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
